limb_normalizer: RTL and testbench
==================================

Name: limb_normalizer

Overview:
- Consumes one signed redundant-limb vector (e.g. a multiplier product: NUM_LIMBS limbs of BIT_LEN+1 bits, nominal radix 2^WORD_LEN).
- Resolves the inter-limb carries serially, one limb per beat, and emits canonical WORD_LEN-bit words LSW-first on a valid/ready stream, plus the final signed carry.
- Sits downstream of the registered multiplier wrapper and converts its output into canonical form for memory or host readback.

Parameters:
- NUM_LIMBS, 35, number of input limbs (2*17+1 product limbs).
- BIT_LEN, 17, input limb MSB index; each limb is signed [BIT_LEN:0].
- WORD_LEN, 16, output word width and radix exponent.
- CARRY_W, BIT_LEN-WORD_LEN+2, signed carry register width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_limbs  in  signed [BIT_LEN:0] x NUM_LIMBS  redundant limbs, index 0 = least significant
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_word  out  WORD_LEN  canonical word (unsigned digit)
- out_idx  out  $clog2(NUM_LIMBS)  index of out_word
- out_last  out  1  high on the word with out_idx==NUM_LIMBS-1
- out_carry  out  signed [CARRY_W-1:0]  final carry (sign/extension of result), valid with out_last

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. All state is sampled on posedge clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_carry=0, carry=0. out_word=0 while out_valid=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture all limbs into a local buffer, carry<=0, idx<=0, go to RUN.
- FSM RUN:
  - in_ready=0, out_valid=1.
  - Combinational sum = sign-extended limb[idx] + carry, computed at width BIT_LEN+2.
  - out_word = sum[WORD_LEN-1:0].
  - On out_valid&&out_ready: carry <= sum >>> WORD_LEN (arithmetic shift), idx <= idx+1.
  - If idx==NUM_LIMBS-1 at handshake, go to IDLE. in_ready rises the next cycle.
- out_carry = sum >>> WORD_LEN, presented while out_last=1.
- Latency: first word valid 1 cycle after input accept. One word per cycle under no backpressure. NUM_LIMBS+1 cycles per vector including the IDLE cycle.
- Backpressure: while out_valid&&!out_ready, out_word, out_idx, out_last, carry and the buffer hold stable. The valid/ready protocol forbids dropping out_valid without a handshake.
- in_valid during RUN is ignored; the producer holds it.
- Outputs depend only on registered state; there is no combinational path from in_* or out_ready to any output.
- Result value = sum over words of out_word*2^(WORD_LEN*i) + out_carry*2^(WORD_LEN*NUM_LIMBS), which equals the signed sum of limb[i]*2^(WORD_LEN*i).
- rst in RUN aborts the vector immediately: the next cycle is IDLE with all outputs at reset values, and the partial vector is discarded.
- rst asserted in the same cycle as an in_valid handshake: reset wins and nothing is captured.

Optional Feature:
- Macro: LIMB_NORMALIZER_OVF_EN.
- Defined: adds output port out_ovf (1 bit).
  - out_ovf is asserted with out_last when the final carry is not 0 and not -1, i.e. the result does not fit in NUM_LIMBS*WORD_LEN bits two's-complement extended by the sign of the final carry.
  - out_ovf reset value is 0.
- Undefined: no out_ovf port and no overflow logic. out_carry still reports the raw carry.

Decomposition:
- Package limb_norm_pkg holds:
  - the state enum (IDLE, RUN);
  - the function computing CARRY_W;
  - the limb typedef signed [BIT_LEN:0];
  - the word typedef [WORD_LEN-1:0].
- One natural sub-module: limb_carry_step (combinational). Inputs are limb and carry; outputs are word and next_carry. It is reusable by a future fully-unrolled variant.

Test Plan:
- All limbs 0 -> 35 words of 0x0000, out_last on idx 34, out_carry=0.
- limb[0]=65536, rest 0 -> word0=0x0000, word1=0x0001, remaining words 0, out_carry=0.
- limb[0]=-1, rest 0 -> all 35 words 0xFFFF, out_carry=-1, out_ovf=0.
- limb[34]=65536 -> word34=0x0000, out_carry=1, out_ovf=1 (macro defined).
- Random limbs with out_ready toggling 50% -> outputs held stable while stalled, and the reconstructed integer equals the reference sum.
- rst pulsed at idx=10 of a vector -> next cycle out_valid=0 and in_ready=1; a following vector normalises correctly from idx 0.

Source files
------------

// File: rtl/limb_normalizer_pkg.sv
`default_nettype none
// ============================================================================
// limb_norm_pkg : shared types and constants for the limb normalizer.
// Rev 1.0
// ============================================================================
package limb_norm_pkg;

  localparam int DEF_NUM_LIMBS = 35;
  localparam int DEF_BIT_LEN   = 17;
  localparam int DEF_WORD_LEN  = 16;

  // Signed carry wide enough for (limb + carry) >>> WORD_LEN, with one guard bit.
  function automatic int carry_width(input int bit_len, input int word_len);
    return bit_len - word_len + 2;
  endfunction

  localparam int DEF_CARRY_W = carry_width(DEF_BIT_LEN, DEF_WORD_LEN);

  typedef logic signed [DEF_BIT_LEN:0] limb_t;
  typedef logic [DEF_WORD_LEN-1:0]     word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/limb_carry_step.sv
`default_nettype none
// ============================================================================
// limb_carry_step : one combinational carry-resolution step (limb + carry).
// Rev 1.0
// ============================================================================
module limb_carry_step
  import limb_norm_pkg::*;
#(
  parameter int BIT_LEN  = DEF_BIT_LEN,
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int CARRY_W  = carry_width(BIT_LEN, WORD_LEN)
) (
  input  logic signed [BIT_LEN:0]   limb_i,
  input  logic signed [CARRY_W-1:0] carry_i,
  output logic [WORD_LEN-1:0]       word_o,
  output logic signed [CARRY_W-1:0] next_carry_o
);

  localparam int SUM_W = BIT_LEN + 2;

  logic signed [SUM_W-1:0] limb_ext;
  logic signed [SUM_W-1:0] carry_ext;
  logic signed [SUM_W-1:0] sum;

  assign limb_ext  = {{(SUM_W-BIT_LEN-1){limb_i[BIT_LEN]}}, limb_i};
  assign carry_ext = {{(SUM_W-CARRY_W){carry_i[CARRY_W-1]}}, carry_i};
  assign sum       = limb_ext + carry_ext;

  // The upper slice is exactly sum >>> WORD_LEN, since SUM_W - WORD_LEN == CARRY_W.
  assign word_o       = sum[WORD_LEN-1:0];
  assign next_carry_o = sum[SUM_W-1:WORD_LEN];

endmodule
`default_nettype wire

// File: rtl/limb_normalizer.sv
`default_nettype none
// ============================================================================
// limb_normalizer : serial carry resolution of a signed redundant-limb vector
// into canonical words, LSW first. LIMB_NORMALIZER_OVF_EN adds out_ovf.
// Rev 1.0
// ============================================================================
module limb_normalizer
  import limb_norm_pkg::*;
#(
  parameter  int NUM_LIMBS = DEF_NUM_LIMBS,
  parameter  int BIT_LEN   = DEF_BIT_LEN,
  parameter  int WORD_LEN  = DEF_WORD_LEN,
  localparam int CARRY_W   = carry_width(BIT_LEN, WORD_LEN),
  localparam int IDX_W     = $clog2(NUM_LIMBS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [BIT_LEN:0]  in_limbs [NUM_LIMBS],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_LEN-1:0]      out_word,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic signed [CARRY_W-1:0] out_carry
`ifdef LIMB_NORMALIZER_OVF_EN
  ,
  output logic                     out_ovf
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  state_e                    state_q, state_d;
  logic signed [BIT_LEN:0]   buf_q [NUM_LIMBS];
  logic signed [CARRY_W-1:0] carry_q;
  logic [IDX_W-1:0]          idx_q;

  logic [WORD_LEN-1:0]       step_word;
  logic signed [CARRY_W-1:0] step_carry;
  logic                      is_last;
  logic                      accept;
  logic                      advance;

  assign is_last = (idx_q == LAST_IDX);
  assign accept  = (state_q == IDLE) && in_valid && !rst;
  assign advance = (state_q == RUN) && out_ready;

  limb_carry_step #(
    .BIT_LEN  (BIT_LEN),
    .WORD_LEN (WORD_LEN),
    .CARRY_W  (CARRY_W)
  ) u_step (
    .limb_i       (buf_q[0]),
    .carry_i      (carry_q),
    .word_o       (step_word),
    .next_carry_o (step_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (out_ready && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_word  = '0;
    out_idx   = idx_q;
    out_last  = 1'b0;
    out_carry = '0;
`ifdef LIMB_NORMALIZER_OVF_EN
    out_ovf   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        out_valid = 1'b1;
        out_word  = step_word;
        out_last  = is_last;
        if (is_last) begin
          out_carry = step_carry;
`ifdef LIMB_NORMALIZER_OVF_EN
          // Anything other than a pure sign extension means lost magnitude.
          out_ovf   = (step_carry != '0) && (step_carry != '1);
`endif
        end
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      carry_q <= '0;
      idx_q   <= '0;
    end else if (advance) begin
      carry_q <= step_carry;
      idx_q   <= is_last ? '0 : idx_q + 1'b1;
    end
  end

  // Limb store shifts down one slot per accepted word, so the active limb is always slot 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q <= in_limbs;
    end else if (advance) begin
      for (int i = 0; i < NUM_LIMBS - 1; i++) begin
        buf_q[i] <= buf_q[i+1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_limb_normalizer.sv
`default_nettype none
// ============================================================================
// tb_limb_normalizer : directed self-checking bench for limb_normalizer.
// Rev 1.0
// ============================================================================
module tb_limb_normalizer;

  localparam int N  = 35;
  localparam int BL = 17;
  localparam int WL = 16;
  localparam int BIGW = 640;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BL:0]   in_limbs [N];
  logic                 out_valid;
  logic                 out_ready;
  logic [WL-1:0]        out_word;
  logic [5:0]           out_idx;
  logic                 out_last;
  logic signed [2:0]    out_carry;
`ifdef LIMB_NORMALIZER_OVF_EN
  logic                 out_ovf;
`endif

  limb_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_limbs  (in_limbs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_carry (out_carry)
`ifdef LIMB_NORMALIZER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [BL:0] vec [N];
  logic [WL-1:0]      got_w [N];
  longint             got_c;
  logic               got_ovf;
  int                 run_cycles;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input string name, input bit stall);
    int k;
    int budget;
    bit held;
    logic [WL-1:0] hw;
    logic [5:0]    hi;
    logic          hl;
    hw = '0; hi = '0; hl = 1'b0;
    in_limbs  = vec;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    budget = 0;
    while (!in_ready && budget < 50) begin
      step();
      budget++;
    end
    chk({name, "_in_ready"}, longint'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk({name, "_first_valid"}, longint'(out_valid), 1);
    k = 0; held = 1'b0; budget = 0;
    while (k < N && budget < 2000) begin
      chk({name, "_valid"}, longint'(out_valid), 1);
      if (held) begin
        chk({name, "_hold_word"}, longint'(out_word), longint'(hw));
        chk({name, "_hold_idx"},  longint'(out_idx),  longint'(hi));
        chk({name, "_hold_last"}, longint'(out_last), longint'(hl));
      end
      chk({name, "_idx"},  longint'(out_idx), k);
      chk({name, "_last"}, longint'(out_last), (k == N-1) ? 1 : 0);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got_w[k] = out_word;
        if (k == N-1) begin
          got_c = out_carry;
`ifdef LIMB_NORMALIZER_OVF_EN
          got_ovf = out_ovf;
`else
          got_ovf = 1'b0;
`endif
        end
        k++;
        held = 1'b0;
      end else begin
        held = out_valid;
        hw = out_word; hi = out_idx; hl = out_last;
      end
      step();
      budget++;
    end
    run_cycles = budget;
    chk({name, "_complete"}, k, N);
    out_ready = 1'b0;
    chk({name, "_done_valid"}, longint'(out_valid), 0);
    chk({name, "_done_ready"}, longint'(in_ready), 1);
  endtask

  // Reference: exact weighted integer sum, independent of the serial carry chain.
  task automatic check_model(input string name);
    logic signed [BIGW-1:0] tot, t, r;
    longint ec;
    tot = '0;
    for (int i = 0; i < N; i++) begin
      t = vec[i];
      t = t <<< (WL * i);
      tot = tot + t;
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_word%0d", name, i), longint'(got_w[i]), longint'(tot[WL*i +: WL]));
    t = tot >>> (WL * N);
    ec = t[63:0];
    chk({name, "_carry"}, got_c, ec);
`ifdef LIMB_NORMALIZER_OVF_EN
    chk({name, "_ovf"}, longint'(got_ovf), (ec != 0 && ec != -1) ? 1 : 0);
`endif
    r = '0;
    for (int i = 0; i < N; i++) begin
      t = '0;
      t[WL-1:0] = got_w[i];
      t = t << (WL * i);
      r = r + t;
    end
    t = got_c;
    t = t <<< (WL * N);
    r = r + t;
    chk({name, "_recon"}, (r == tot) ? 1 : 0, 1);
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < N; i++) vec[i] = BL'(0);
    vec[0] = (BL+1)'(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_limbs[i] = '0;
    got_c = 0; got_ovf = 1'b0; run_cycles = 0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready",  longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_idx",   longint'(out_idx), 0);
    chk("rst_out_last",  longint'(out_last), 0);
    chk("rst_out_carry", longint'(out_carry), 0);
    chk("rst_out_word",  longint'(out_word), 0);

    // All zero
    fill(0);
    run_vector("zero", 1'b0);
    chk("zero_cycles", run_cycles, N);
    for (int i = 0; i < N; i++) chk($sformatf("zero_w%0d", i), longint'(got_w[i]), 0);
    chk("zero_carry", got_c, 0);

    // limb0 = 65536 carries into word1
    fill(65536);
    run_vector("c1", 1'b0);
    chk("c1_w0", longint'(got_w[0]), 0);
    chk("c1_w1", longint'(got_w[1]), 1);
    chk("c1_w2", longint'(got_w[2]), 0);
    chk("c1_carry", got_c, 0);
    check_model("c1");

    // limb0 = -1 sign-extends across every word
    fill(-1);
    run_vector("neg", 1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("neg_w%0d", i), longint'(got_w[i]), 16'hFFFF);
    chk("neg_carry", got_c, -1);
`ifdef LIMB_NORMALIZER_OVF_EN
    chk("neg_ovf", longint'(got_ovf), 0);
`endif

    // Top limb overflows into the final carry
    fill(0);
    vec[N-1] = 18'sd65536;
    run_vector("top", 1'b0);
    chk("top_w34", longint'(got_w[N-1]), 0);
    chk("top_carry", got_c, 1);
`ifdef LIMB_NORMALIZER_OVF_EN
    chk("top_ovf", longint'(got_ovf), 1);
`endif

    // All limbs at positive maximum
    for (int i = 0; i < N; i++) vec[i] = 18'sd131071;
    run_vector("max", 1'b0);
    check_model("max");

    // Random limbs under 50% backpressure
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        rv = $urandom;
        vec[i] = rv[BL:0];
      end
      run_vector($sformatf("rnd%0d", t), 1'b1);
      check_model($sformatf("rnd%0d", t));
    end

    // Reset in the middle of a vector
    for (int i = 0; i < N; i++) vec[i] = 18'sd70000 - 18'(i);
    in_limbs = vec; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("abort_idx_before", longint'(out_idx), 10);
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_valid", longint'(out_valid), 0);
    chk("abort_ready", longint'(in_ready), 1);
    chk("abort_idx",   longint'(out_idx), 0);
    chk("abort_word",  longint'(out_word), 0);
    chk("abort_carry", longint'(out_carry), 0);
    fill(-5);
    vec[7] = -18'sd131072;
    run_vector("after", 1'b0);
    check_model("after");

    // Reset wins over a simultaneous accept
    fill(1);
    in_limbs = vec; in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstacc_valid", longint'(out_valid), 0);
    chk("rstacc_ready", longint'(in_ready), 1);
    step();
    chk("rstacc_valid2", longint'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
